// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS definitions: fetch FSM states, reset PC, instruction fields, opcodes
package mips_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] func_of(input logic [31:0] instr);
        return instr[FUNC_MSB:FUNC_LSB];
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// rtl/fetch_slot.sv - single-entry valid/ready output register holding a fetched instruction and its PC
module fetch_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // Flush wins over a same-cycle load so a redirect discards the arriving word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, single outstanding imem read, redirect flush; option FETCH_ALIGN_CHECK_EN
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_misalign
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  redirect_target;
    logic         redirect_take;
    logic         misalign_hit;
    logic         req_now;
    logic         outstanding;
    logic         slot_load;
    logic         slot_flush;

    assign redirect_take = redirect_valid && (state != S_HALT);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
    assign misalign_hit    = redirect_take && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst)
            fetch_misalign <= 1'b0;
        else if (misalign_hit)
            fetch_misalign <= 1'b1;
    end
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign misalign_hit        = 1'b0;
    assign fetch_misalign      = 1'b0;
`endif

    always_comb begin
        req_now     = !rst && (state == S_REQ) && (!id_valid || id_ready);
        state_next  = state;
        pc_next     = pc;
        slot_load   = 1'b0;
        slot_flush  = 1'b0;
        outstanding = 1'b0;

        case (state)
            S_REQ:  if (req_now) state_next = S_WAIT;
            S_WAIT: if (imem_rvalid) begin
                        slot_load  = 1'b1;
                        pc_next    = pc + 32'd4;
                        state_next = S_REQ;
                    end
            S_DROP: if (imem_rvalid) state_next = S_REQ;
            default: state_next = S_HALT;
        endcase

        // A redirect must still account for a read that stays in flight past this cycle.
        if (redirect_take) begin
            slot_load   = 1'b0;
            slot_flush  = 1'b1;
            outstanding = ((state == S_WAIT || state == S_DROP) && !imem_rvalid)
                        || ((state == S_REQ) && req_now);
            if (misalign_hit) begin
                pc_next    = pc;
                state_next = S_HALT;
            end else begin
                pc_next    = redirect_target;
                state_next = outstanding ? S_DROP : S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    assign imem_req  = req_now;
    assign imem_addr = pc;

    fetch_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (slot_load),
        .flush      (slot_flush),
        .ready      (id_ready),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc),
        .pc_plus4   (id_pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch with a latency-configurable imem model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_misalign;

    int total = 0;
    int bad   = 0;

    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;
    logic        last_req;
    logic [31:0] last_addr;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Samples the request of the current cycle, advances one clock, then drives any due response.
    task automatic tick();
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (last_req && !rst) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = last_addr;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int l);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        imem_rvalid    = 1'b0;
        pend           = 1'b0;
        lat            = l;
        tick();
        tick();
        pend        = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        imem_rvalid    = 1'b0;
        pend           = 1'b0;
        cnt            = 0;
        paddr          = 32'h0;

        // Reset release, L=1, sequential fetch
        do_reset(1);
        check("rst_req", last_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_instr", id_instr, 0);
        check("rst_pc", id_pc, 0);
        check("rst_misalign", fetch_misalign, 0);
        rst = 1'b0;
        tick();
        check("seq_req0", last_req, 1);
        check("seq_addr0", last_addr, 32'h0);
        tick();
        check("seq_wait_noreq", last_req, 0);
        check("seq_valid0", id_valid, 1);
        check("seq_instr0", id_instr, mem_word(32'h0));
        check("seq_pc0", id_pc, 32'h0);
        check("seq_pc4_0", id_pc_plus4, 32'h4);
        tick();
        check("seq_req1", last_req, 1);
        check("seq_addr1", last_addr, 32'h4);
        check("seq_drained", id_valid, 0);
        tick();
        check("seq_valid1", id_valid, 1);
        check("seq_pc1", id_pc, 32'h4);
        check("seq_pc4_1", id_pc_plus4, 32'h8);

        // Backpressure with a full slot
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_noreq", last_req, 0);
            check("bp_instr", id_instr, mem_word(32'h4));
        end
        check("bp_valid", id_valid, 1);
        id_ready = 1'b1;
        tick();
        check("bp_release_req", last_req, 1);
        check("bp_release_addr", last_addr, 32'h8);
        tick();
        check("bp_pc2", id_pc, 32'h8);
        check("bp_instr2", id_instr, mem_word(32'h8));

        // Redirect while waiting, L=3: late response dropped
        do_reset(3);
        rst = 1'b0;
        tick();
        check("rw_req0", last_req, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("rw_flush_valid", id_valid, 0);
        tick();
        check("rw_drop_noreq0", last_req, 0);
        tick();
        check("rw_drop_noreq1", last_req, 0);
        check("rw_drop_valid", id_valid, 0);
        tick();
        check("rw_target_req", last_req, 1);
        check("rw_target_addr", last_addr, 32'h100);
        tick();
        tick();
        tick();
        check("rw_valid", id_valid, 1);
        check("rw_pc", id_pc, 32'h100);
        check("rw_instr", id_instr, mem_word(32'h100));

        // Redirect on the same cycle as the response
        do_reset(1);
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("rs_noreq", last_req, 0);
        check("rs_valid", id_valid, 0);
        tick();
        check("rs_req", last_req, 1);
        check("rs_addr", last_addr, 32'h200);
        tick();
        check("rs_pc", id_pc, 32'h200);
        check("rs_instr", id_instr, mem_word(32'h200));

        // Redirect while a request issues: that request's response is dropped
        do_reset(1);
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("ri_req_old", last_req, 1);
        check("ri_addr_old", last_addr, 32'h0);
        tick();
        check("ri_drop_noreq", last_req, 0);
        check("ri_drop_valid", id_valid, 0);
        tick();
        check("ri_req_new", last_req, 1);
        check("ri_addr_new", last_addr, 32'h300);

        // PC wrap at the top of the address space
        do_reset(1);
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wr_addr_top", last_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_pc", id_pc, 32'hFFFF_FFFC);
        check("wr_pc4", id_pc_plus4, 32'h0);
        tick();
        check("wr_req", last_req, 1);
        check("wr_addr_wrap", last_addr, 32'h0);

        // Misaligned redirect
        do_reset(1);
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("ma_flag", fetch_misalign, 1);
        check("ma_valid", id_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ma_halt_noreq", last_req, 0);
        end
        do_reset(1);
        check("ma_flag_cleared", fetch_misalign, 0);
`else
        check("ma_flag", fetch_misalign, 0);
        tick();
        check("ma_req", last_req, 1);
        check("ma_addr", last_addr, 32'h100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS CPU, directly upstream of the decode/controller stage. Holds the PC, issues one instruction-memory read at a time, and presents the returned word with its PC in a single-entry valid/ready output slot; decode slices opcode `id_instr[31:26]` and func `id_instr[5:0]` from it. Accepts a redirect (jr/branch/jump target) that flushes in-flight work.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  read request, one-cycle pulse; request accepted unconditionally
- `imem_addr`  out  32  read address (= PC), valid when `imem_req`=1
- `imem_rvalid`  in  1  read data valid, ≥1 cycle after request
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  load new PC, flush
- `redirect_pc`  in  32  redirect target
- `id_valid`  out  1  output slot holds an instruction
- `id_ready`  in  1  decode consumes slot when `id_valid & id_ready`
- `id_instr`  out  32  instruction word
- `id_pc`  out  32  PC of `id_instr`
- `id_pc_plus4`  out  32  `id_pc + 4`, mod 2^32
- `fetch_misalign`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: S_REQ, S_WAIT, S_DROP, S_HALT. At most one outstanding memory request.
- S_REQ: `imem_req = !id_valid | id_ready` (slot empty or draining this cycle); `imem_addr = pc`. If request issued → S_WAIT, else stay.
- S_WAIT: on `imem_rvalid`: load slot (`id_instr<=imem_rdata`, `id_pc<=pc`, `id_valid<=1`), `pc<=pc+4` → S_REQ. Slot is guaranteed empty on arrival.
- Slot drain: `id_valid & id_ready` clears `id_valid` unless a load happens the same cycle.
- Redirect (any state except S_HALT): `pc<=redirect_pc`, `id_valid<=0`. Next state: S_REQ if no request outstanding after this cycle (in S_WAIT with `imem_rvalid` same cycle, or in S_REQ with no request issued); S_DROP if a request is outstanding (S_WAIT without rvalid, S_REQ issuing this cycle, S_DROP without rvalid).
- Redirect beats `imem_rvalid` in the same cycle: that response is discarded.
- S_DROP: `imem_req=0`; on `imem_rvalid` discard data → S_REQ.
- `imem_rvalid` in S_REQ/S_HALT: ignored.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset: state S_REQ, `pc=RESET_PC`, `id_valid=0`, `id_instr=0`, `id_pc=0`, `fetch_misalign=0`; `imem_req=0` while `rst`=1, first request on the first cycle after deassertion.
- Reset mid-operation aborts any outstanding request; a late response arrives in S_REQ and is ignored.
- Memory latency L ≥ 1: req at t, rvalid at t+L, `id_valid` at t+L+1, next req at t+L+1 if `id_ready`. Throughput one instruction per L+1 cycles.
- Redirect at t: first request to target at t+1 (no outstanding) or the cycle after the discarded response.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]!=0` sets `fetch_misalign<=1`, clears `id_valid`, → S_HALT (no requests, responses ignored) until `rst`.
- Undefined: `redirect_pc[1:0]` forced to 00, `fetch_misalign` tied 0, S_HALT unreachable.

## Structure
- Shared package `mips_pkg`: FSM state enum, `RESET_PC` default, instruction field ranges (opcode [31:26], func [5:0]), FN_* / opcode constants shared with the controller.
- One natural sub-module: `fetch_slot` — output register with valid/ready, load/flush inputs.

## Test plan
- Reset release, L=1, `id_ready`=1 → requests at 0x0, 0x4, 0x8 every 2 cycles; `id_pc`/`id_pc_plus4` = 0x0/0x4, 0x4/0x8.
- `id_ready`=0 for 5 cycles with slot full → no `imem_req`, `id_instr` stable; `id_ready`=1 → request next address same cycle.
- Redirect to 0x100 in S_WAIT, response at +2 → response dropped, `id_valid`=0, next request 0x100.
- Redirect same cycle as `imem_rvalid` → data discarded, request 0x100 next cycle.
- PC 0xFFFF_FFFC fetched → `id_pc_plus4`=0, next request address 0x0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fetch_misalign`=1, no further requests until `rst`; without it → request to 0x100.
